// File: rtl/serial_job_pkg.sv
// Shared types and helpers for the serial job front end: TX state encoding and a
// constant-evaluable clog2 used to size counters, pointers and ports.
package serial_job_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_LOAD  = 2'd1,
      TX_START = 2'd2,
      TX_WAIT  = 2'd3
   } tx_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_result_fifo.sv
// Synchronous result FIFO, head visible combinationally, level/empty reported; 0-cycle read, 1-cycle write.
// A push while full is accepted only if a pop frees a slot that cycle, otherwise it is dropped and flagged.
module serial_result_fifo
   import serial_job_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW   = clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dat,
   output logic [AW:0]      o_level,
   output logic             o_empty,
   output logic             o_drop
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic [AW:0]      w_level;
   logic             w_full;
   logic             w_do_pop;
   logic             w_do_push;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   assign w_level   = r_wr - r_rd;
   assign w_full    = (w_level == (AW+1)'(DEPTH));
   assign o_empty   = (w_level == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);
   assign o_drop    = i_push && !w_do_push;
   assign o_level   = w_level;
   assign o_dat     = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_dat;
   end

endmodule

// File: rtl/uart.sv
// 8N1 UART with no reset: RX delivers a byte with a one-cycle ready pulse after the stop-bit sample,
// TX takes a byte on tx_start while idle; tx_start is ignored while busy (no queueing).
module uart
   import serial_job_pkg::*;
#(
   parameter int CLOCK        = 100000000,
   parameter int BAUD         = 115200,
   parameter int SAMPLE_POINT = 8
) (
   input  logic       i_clk,
   input  logic       i_rx,
   output logic       o_tx,
   input  logic       i_tx_start,
   input  logic [7:0] i_tx_byte,
   output logic       o_tx_busy,
   output logic       o_rx_data_ready,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_busy
);

   localparam int DIV = CLOCK / BAUD;
   localparam int CW  = clog2(DIV + 1);
   // SAMPLE_POINT is in sixteenths of a bit period
   localparam int SP  = (DIV * SAMPLE_POINT) / 16;

   logic          r_rx_s1;
   logic          r_rx_s2;
   logic          r_rx_act;
   logic [CW-1:0] r_rx_cnt;
   logic [3:0]    r_rx_bit;
   logic [7:0]    r_rx_sh;
   logic          r_rx_rdy;

   // Counters use >= so an arbitrary power-up state still drains back to idle.
   always_ff @(posedge i_clk) begin
      r_rx_s1  <= i_rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_rdy <= 1'b0;
      if (!r_rx_act) begin
         if (!r_rx_s2) begin
            r_rx_act <= 1'b1;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
         end
      end else begin
         if (r_rx_cnt == CW'(SP)) begin
            if (r_rx_bit == 4'd0) begin
               if (r_rx_s2) r_rx_act <= 1'b0;
            end else if (r_rx_bit >= 4'd9) begin
               r_rx_act <= 1'b0;
               r_rx_rdy <= r_rx_s2;
            end else begin
               r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
            end
         end
         if (r_rx_cnt >= CW'(DIV - 1)) begin
            r_rx_cnt <= '0;
            r_rx_bit <= r_rx_bit + 4'd1;
         end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
         end
      end
   end

   assign o_rx_data_ready = r_rx_rdy;
   assign o_rx_byte       = r_rx_sh;
   assign o_rx_busy       = r_rx_act;

   logic          r_tx_act;
   logic [CW-1:0] r_tx_cnt;
   logic [3:0]    r_tx_bit;
   logic [9:0]    r_tx_sh;

   always_ff @(posedge i_clk) begin
      if (!r_tx_act) begin
         if (i_tx_start) begin
            r_tx_act <= 1'b1;
            r_tx_sh  <= {1'b1, i_tx_byte, 1'b0};
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
         end
      end else if (r_tx_cnt >= CW'(DIV - 1)) begin
         r_tx_cnt <= '0;
         r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
         if (r_tx_bit >= 4'd9) r_tx_act <= 1'b0;
         else                  r_tx_bit <= r_tx_bit + 4'd1;
      end else begin
         r_tx_cnt <= r_tx_cnt + 1'b1;
      end
   end

   assign o_tx      = r_tx_act ? r_tx_sh[0] : 1'b1;
   assign o_tx_busy = r_tx_act;

endmodule

// File: rtl/serial_job_core.sv
// UART front end: assembles RX frames into job_data (valid 1 clk after last byte) and sends queued result words MSB first.
// Results are never back-pressured: a push into a full FIFO is dropped and sets a sticky overflow flag.
module serial_job_core
   import serial_job_pkg::*;
#(
   parameter int CLOCK        = 100000000,
   parameter int BAUD         = 115200,
   parameter int SAMPLE_POINT = 8,
   parameter int RX_BYTES     = 64,
   parameter int TX_BYTES     = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int RX_TIMEOUT   = CLOCK / BAUD * 40
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_rx,
   output logic                         o_tx,
   output logic [RX_BYTES*8-1:0]        o_job_data,
   output logic                         o_job_valid,
   input  logic [TX_BYTES*8-1:0]        i_res_data,
   input  logic                         i_res_valid,
   output logic [clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                         o_overflow,
   output logic                         o_rx_busy,
   output logic                         o_tx_busy
);

   localparam int RXW  = RX_BYTES * 8;
   localparam int TXW  = TX_BYTES * 8;
   localparam int CNTW = clog2(RX_BYTES + 1);
   localparam int TOW  = clog2(RX_TIMEOUT + 1);
   localparam int IDXW = clog2(TX_BYTES + 1);

   logic       w_rx_rdy;
   logic [7:0] w_rx_byte;
   logic       w_uart_rx_busy;
   logic       w_uart_tx_busy;
   logic       w_tx_start;
   logic [7:0] w_tx_byte;

   uart #(
      .CLOCK        (CLOCK),
      .BAUD         (BAUD),
      .SAMPLE_POINT (SAMPLE_POINT)
   ) u_uart (
      .i_clk           (i_clk),
      .i_rx            (i_rx),
      .o_tx            (o_tx),
      .i_tx_start      (w_tx_start),
      .i_tx_byte       (w_tx_byte),
      .o_tx_busy       (w_uart_tx_busy),
      .o_rx_data_ready (w_rx_rdy),
      .o_rx_byte       (w_rx_byte),
      .o_rx_busy       (w_uart_rx_busy)
   );

   logic [CNTW-1:0] r_rx_cnt;
   logic [TOW-1:0]  r_to_cnt;
   logic [RXW-1:0]  r_job_data;
   logic            r_job_vld;
   logic            r_rx_skip;
   logic            w_rx_take;
   logic [RXW-1:0]  w_frame;

   // The uart is not reset, so a byte already in flight at reset is discarded when it lands.
   assign w_rx_take = w_rx_rdy && !r_rx_skip;

   generate
      if (RX_BYTES > 1) begin : g_shadow
         logic [RXW-9:0] r_shadow;
         always_ff @(posedge i_clk) begin
            if (w_rx_take) r_shadow <= w_frame[RXW-9:0];
         end
         assign w_frame = {r_shadow, w_rx_byte};
      end else begin : g_no_shadow
         assign w_frame = w_rx_byte;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_cnt   <= '0;
         r_to_cnt   <= '0;
         r_job_data <= '0;
         r_job_vld  <= 1'b0;
         r_rx_skip  <= 1'b1;
      end else begin
         r_job_vld <= 1'b0;
         if (!w_uart_rx_busy) r_rx_skip <= 1'b0;
         if (w_rx_take) begin
            r_to_cnt <= '0;
            if (r_rx_cnt == CNTW'(RX_BYTES - 1)) begin
               r_rx_cnt   <= '0;
               r_job_data <= w_frame;
               r_job_vld  <= 1'b1;
            end else begin
               r_rx_cnt <= r_rx_cnt + 1'b1;
            end
         end else if (r_rx_cnt != '0) begin
            if (r_to_cnt == TOW'(RX_TIMEOUT)) r_rx_cnt <= '0;
            else                              r_to_cnt <= r_to_cnt + 1'b1;
         end else begin
            r_to_cnt <= '0;
         end
      end
   end

   assign o_job_data  = r_job_data;
   assign o_job_valid = r_job_vld;
   assign o_rx_busy   = (r_rx_cnt != '0);

   logic [TXW-1:0]            w_fifo_dat;
   logic [clog2(FIFO_DEPTH):0] w_fifo_level;
   logic                      w_fifo_empty;
   logic                      w_fifo_drop;
   logic                      w_pop;
   logic                      r_overflow;

   serial_result_fifo #(
      .WIDTH (TXW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (i_res_valid),
      .i_dat   (i_res_data),
      .i_pop   (w_pop),
      .o_dat   (w_fifo_dat),
      .o_level (w_fifo_level),
      .o_empty (w_fifo_empty),
      .o_drop  (w_fifo_drop)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset)          r_overflow <= 1'b0;
      else if (w_fifo_drop) r_overflow <= 1'b1;
   end

   assign o_fifo_level = w_fifo_level;
   assign o_overflow   = r_overflow;

   tx_state_t       r_tx_state;
   tx_state_t       w_tx_state_nxt;
   logic [TXW-1:0]  r_tx_shift;
   logic [TXW-1:0]  w_tx_shift_nxt;
   logic [IDXW-1:0] r_tx_idx;
   logic [IDXW-1:0] w_tx_idx_nxt;
   logic            r_tx_skip;
   logic            w_tx_skip_nxt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tx_state <= TX_IDLE;
         r_tx_shift <= '0;
         r_tx_idx   <= '0;
         r_tx_skip  <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_tx_idx   <= w_tx_idx_nxt;
         r_tx_skip  <= w_tx_skip_nxt;
      end
   end

   // The first WAIT cycle ignores uart busy, which only rises the cycle after tx_start.
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_idx_nxt   = r_tx_idx;
      w_tx_skip_nxt  = r_tx_skip;
      w_pop          = 1'b0;
      w_tx_start     = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            if (!w_fifo_empty && !w_uart_tx_busy) w_tx_state_nxt = TX_LOAD;
         end
         TX_LOAD: begin
            w_tx_shift_nxt = w_fifo_dat;
            w_pop          = 1'b1;
            w_tx_idx_nxt   = '0;
            w_tx_state_nxt = TX_START;
         end
         TX_START: begin
            w_tx_start     = 1'b1;
            w_tx_shift_nxt = r_tx_shift << 8;
            w_tx_skip_nxt  = 1'b1;
            w_tx_state_nxt = TX_WAIT;
         end
         TX_WAIT: begin
            if (r_tx_skip) begin
               w_tx_skip_nxt = 1'b0;
            end else if (!w_uart_tx_busy) begin
               if (r_tx_idx == IDXW'(TX_BYTES - 1)) begin
                  w_tx_state_nxt = TX_IDLE;
               end else begin
                  w_tx_idx_nxt   = r_tx_idx + 1'b1;
                  w_tx_state_nxt = TX_START;
               end
            end
         end
      endcase
   end

   assign w_tx_byte = r_tx_shift[TXW-1 -: 8];
   assign o_tx_busy = !w_fifo_empty || (r_tx_state != TX_IDLE);

endmodule

// File: tb/tb_serial_job_core.sv
// Scoreboard bench for serial_job_core: stimulus queues expected jobs and TX bytes,
// independent monitors decode the tx line and job_valid strobes and compare.
module tb_serial_job_core;
   import serial_job_pkg::*;

   localparam int DIV = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic        tx;
   logic [31:0] job_data;
   logic        job_valid;
   logic [31:0] res_data = '0;
   logic        res_valid = 1'b0;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        rx_busy;
   logic        tx_busy;

   serial_job_core #(
      .CLOCK        (1000000),
      .BAUD         (100000),
      .SAMPLE_POINT (8),
      .RX_BYTES     (4),
      .TX_BYTES     (4),
      .FIFO_DEPTH   (4),
      .RX_TIMEOUT   (400)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_rx         (rx),
      .o_tx         (tx),
      .o_job_data   (job_data),
      .o_job_valid  (job_valid),
      .i_res_data   (res_data),
      .i_res_valid  (res_valid),
      .o_fifo_level (fifo_level),
      .o_overflow   (overflow),
      .o_rx_busy    (rx_busy),
      .o_tx_busy    (tx_busy)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_job[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(DIV);
      end
      rx = 1'b1;
      tick(DIV);
   endtask

   task automatic send_frame(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic expect_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
   endtask

   task automatic push_word(input logic [31:0] w);
      res_data  = w;
      res_valid = 1'b1;
      tick(1);
      res_valid = 1'b0;
   endtask

   task automatic wait_level0(input string name);
      int b = 0;
      while (fifo_level !== 3'd0 && b < 1000) begin
         tick(1);
         b++;
      end
      check(name, fifo_level, 3'd0);
   endtask

   task automatic wait_drain(input string name);
      int b = 0;
      while (tx_busy !== 1'b0 && b < 3000) begin
         tick(1);
         b++;
      end
      check(name, tx_busy, 1'b0);
      tick(3);
      check({name, " queue"}, exp_tx.size(), 0);
      check({name, " line"}, tx, 1'b1);
   endtask

   // TX line decoder, sampling mid-bit on the falling clock edge
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            repeat (15) @(negedge clk);
            b[0] = tx;
            for (int i = 1; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = tx;
            end
            repeat (DIV) @(negedge clk);
            check("tx stop bit", tx, 1'b1);
            if (exp_tx.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL tx unexpected byte: got 0x%0h, expected none", b);
            end else begin
               check("tx byte", b, exp_tx.pop_front());
            end
         end
      end
   end

   // Job monitor; job_valid must follow the uart byte strobe by exactly one clock
   initial begin
      logic prev_rdy;
      prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (job_valid === 1'b1) begin
            check("job latency", prev_rdy, 1'b1);
            if (exp_job.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL job unexpected: got 0x%0h, expected none", job_data);
            end else begin
               check("job data", job_data, exp_job.pop_front());
            end
         end
         prev_rdy = dut.w_rx_rdy;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      // reset state
      tick(3);
      check("rst job_valid", job_valid, 1'b0);
      check("rst job_data", job_data, 32'h0);
      check("rst fifo_level", fifo_level, 3'd0);
      check("rst overflow", overflow, 1'b0);
      check("rst rx_busy", rx_busy, 1'b0);
      check("rst tx_busy", tx_busy, 1'b0);
      check("rst tx", tx, 1'b1);
      reset = 1'b0;
      tick(5);

      // 1: single frame
      exp_job.push_back(32'h11223344);
      send_frame(32'h11223344);
      tick(5);
      check("t1 job_data", job_data, 32'h11223344);
      check("t1 rx_busy", rx_busy, 1'b0);
      check("t1 job count", exp_job.size(), 0);

      // 2: partial frame times out
      send_byte(8'hAA);
      send_byte(8'hBB);
      check("t2 rx_busy partial", rx_busy, 1'b1);
      tick(500);
      check("t2 rx_busy timeout", rx_busy, 1'b0);
      check("t2 job_data held", job_data, 32'h11223344);
      exp_job.push_back(32'h01020304);
      send_frame(32'h01020304);
      tick(5);
      check("t2 job_data", job_data, 32'h01020304);

      // 3: one result word
      expect_word(32'hDEADBEEF);
      push_word(32'hDEADBEEF);
      check("t3 level push", fifo_level, 3'd1);
      tick(1);
      check("t3 level idle", fifo_level, 3'd1);
      tick(1);
      check("t3 level load", fifo_level, 3'd0);
      wait_drain("t3 drain");

      // 4a: five back-to-back pushes while idle
      for (int i = 1; i <= 5; i++) begin
         expect_word(32'(i));
         res_data  = 32'(i);
         res_valid = 1'b1;
         tick(1);
      end
      res_valid = 1'b0;
      check("t4a level", fifo_level, 3'd4);
      check("t4a overflow", overflow, 1'b0);
      wait_drain("t4a drain");

      // 6: push coinciding with LOAD while full
      expect_word(32'hA0A1A2A3);
      push_word(32'hA0A1A2A3);
      wait_level0("t6 first popped");
      for (int i = 0; i < 4; i++) begin
         expect_word(32'hB0B0B0B0 + 32'(i));
         res_data  = 32'hB0B0B0B0 + 32'(i);
         res_valid = 1'b1;
         tick(1);
      end
      res_valid = 1'b0;
      check("t6 level full", fifo_level, 3'd4);
      b = 0;
      while (dut.r_tx_state !== TX_LOAD && b < 1000) begin
         tick(1);
         b++;
      end
      check("t6 reached load", dut.r_tx_state, TX_LOAD);
      check("t6 level before", fifo_level, 3'd4);
      expect_word(32'h66666666);
      push_word(32'h66666666);
      check("t6 level after", fifo_level, 3'd4);
      check("t6 overflow", overflow, 1'b0);
      wait_drain("t6 drain");

      // 4b: six pushes while mid-word, FIFO empty
      expect_word(32'hC0C0C0C0);
      push_word(32'hC0C0C0C0);
      wait_level0("t4b first popped");
      for (int i = 0; i < 6; i++) begin
         if (i < 4) expect_word(32'hD0D0D0D0 + 32'(i));
         res_data  = 32'hD0D0D0D0 + 32'(i);
         res_valid = 1'b1;
         tick(1);
      end
      res_valid = 1'b0;
      check("t4b overflow", overflow, 1'b1);
      check("t4b level", fifo_level, 3'd4);
      wait_drain("t4b drain");
      check("t4b overflow sticky", overflow, 1'b1);

      // 5: reset during RX byte 2 and TX word 2
      expect_word(32'h5A5A0001);
      exp_tx.push_back(8'h12);
      push_word(32'h5A5A0001);
      push_word(32'h12345678);
      tick(330);
      send_byte(8'h77);
      rx = 1'b0;
      tick(DIV);
      rx = 1'b1;
      tick(DIV * 2);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      check("t5 job_valid", job_valid, 1'b0);
      check("t5 job_data", job_data, 32'h0);
      check("t5 fifo_level", fifo_level, 3'd0);
      check("t5 overflow", overflow, 1'b0);
      check("t5 rx_busy", rx_busy, 1'b0);
      check("t5 tx_busy", tx_busy, 1'b0);
      tick(150);
      exp_job.push_back(32'hC0FFEE01);
      send_frame(32'hC0FFEE01);
      tick(5);
      check("t5 job after reset", job_data, 32'hC0FFEE01);
      tick(300);
      check("t5 tx_busy end", tx_busy, 1'b0);
      check("t5 tx queue", exp_tx.size(), 0);
      check("t5 job queue", exp_job.size(), 0);
      check("t5 rx_busy end", rx_busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
